seq_logic_reducer: RTL and testbench
====================================

// Module: seq_logic_reducer
// PURPOSE
//  Parametrised sequential bitwise logic unit; successor to the single-bit 2-input OR.
//  Accepts a stream of COUNT operands, each WIDTH bits wide, over a valid/ready handshake.
//  Reduces them with a selectable op (OR/AND/XOR/NOR) and presents one registered result.
//  Sits between an operand source (switches/testbench/CPU port) and a result sink.
// PARAMETERS
//  WIDTH  8  operand and result width in bits (>=1)
//  COUNT  4  operands per reduction (>=1); internal counter width is $clog2(COUNT+1)
// PORTS
//  CLK        in   1      single clock, all state updates on posedge
//  RST        in   1      synchronous, active-high reset
//  in_valid   in   1      operand present on in_data
//  in_ready   out  1      block can accept an operand this cycle
//  in_data    in   WIDTH  operand
//  op         in   2      00=OR 01=AND 10=XOR 11=NOR; sampled only with the first operand
//  flush      in   1      abort any partial reduction
//  out_valid  out  1      result held on out_data
//  out_ready  in   1      sink accepts result
//  out_data   out  WIDTH  registered reduction result
// BEHAVIOUR
//  Transfer: an operand is accepted when in_valid & in_ready at posedge. A result is taken when out_valid & out_ready.
//  FSM:
//   - IDLE: on accept -> latch op, acc=f(identity,in_data), cnt=1; -> DONE if COUNT==1, else -> ACCUM.
//   - ACCUM: on accept -> acc=f(acc,in_data), cnt+1; -> DONE when the COUNT-th operand is accepted.
//   - DONE: out_valid=1; on out_ready -> IDLE.
//  Identity: OR/XOR/NOR=0, AND=all ones. NOR accumulates as OR; out_data=~acc for NOR only.
//  in_ready = (state!=DONE) & ~flush; combinational, no dependence on in_valid.
//  Latency: out_valid rises the cycle after the last operand is accepted.
//   - Min cycles per result = COUNT+1 (no accept in DONE, no bypass).
//  Backpressure: while out_valid & ~out_ready, out_data and out_valid are held stable; in_ready=0.
//  op changes after the first operand are ignored until the next IDLE accept.
//  flush:
//   - In IDLE/ACCUM -> IDLE next cycle, acc and cnt cleared, any same-cycle operand dropped.
//   - In DONE -> ignored; the result is not discarded.
//  RST (wins over all inputs): state=IDLE, acc=0, cnt=0, latched op=OR, out_valid=0, out_data=0.
//   - in_ready=1 in the cycle after the reset edge.
//  Mid-operation reset discards partial state; no result is emitted for it.
//  Arithmetic: purely bitwise, no carries; cnt never exceeds COUNT (no wrap).
// CONFIGURATION
//  LOGRED_TRACE_EN defined:
//   - each accepted operand prints "%2d: in %h" with $time.
//   - each result handoff prints "%2d: op %d -> %h".
//   - simulation only; no port/timing change.
//  LOGRED_TRACE_EN undefined: no $display code compiled; RTL identical otherwise.
// TESTING (WIDTH=8, COUNT=4, out_ready=1 unless stated)
//  1 op=OR, in 01,02,04,08 back-to-back -> out_valid 1 cycle after 4th accept, out_data=0F.
//  2 op=AND, in FF,F0,3C,FF -> 30; op=XOR, in 55,AA,0F,00 -> F0; op=NOR, in 00 x4 -> FF.
//  3 backpressure: result 0F, out_ready=0 for 5 cycles -> out_data=0F stable, in_ready=0; then 1 -> IDLE.
//  4 flush after 2 OR operands (80,40), then op=OR in 10,00,00,01 -> 11 (not D1).
//    - flush with in_valid high: operand dropped, in_ready=0 that cycle.
//  5 op toggled to AND after first OR operand 0F, rest 00,00,F0 -> FF (OR retained).
//  6 RST during ACCUM (2 operands in) -> next cycle out_valid=0, out_data=00, in_ready=1.
//    - a following OR of 01,01,01,01 -> 01.

Source files
------------

// File: rtl/seq_logic_reducer.sv
// Streams COUNT operands through a selectable bitwise reduction (OR/AND/XOR/NOR).
// Optional LOGRED_TRACE_EN macro adds simulation-only transfer tracing.
module seq_logic_reducer #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] acc;
    logic [1:0]      op_q;

    logic             accept;
    logic [1:0]       cur_op;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] nxt_acc;
    logic [WIDTH-1:0] nxt_res;

    assign in_ready = (state != DONE) & ~flush;
    assign accept   = in_valid & in_ready;

    // The first operand starts from the identity of the op sampled with it.
    always_comb begin
        cur_op = (state == IDLE) ? op : op_q;
        base   = acc;
        if (state == IDLE)
            base = (op == OP_AND) ? '1 : '0;
        unique case (cur_op)
            OP_AND:  nxt_acc = base & in_data;
            OP_XOR:  nxt_acc = base ^ in_data;
            default: nxt_acc = base | in_data;
        endcase
        nxt_res = (cur_op == OP_NOR) ? ~nxt_acc : nxt_acc;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            op_q      <= 2'b00;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (accept) begin
                        op_q <= op;
                        acc  <= nxt_acc;
                        cnt  <= CW'(1);
                        if (COUNT == 1) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= nxt_res;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (flush) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (accept) begin
                        acc <= nxt_acc;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= nxt_res;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOGRED_TRACE_EN
    always @(posedge CLK) begin
        if (!RST) begin
            if (accept)
                $display("%2d: in %h", $time, in_data);
            if (out_valid && out_ready)
                $display("%2d: op %d -> %h", $time, op_q, out_data);
        end
    end
`endif

endmodule

// File: tb/tb_seq_logic_reducer.sv
// Self-checking bench for seq_logic_reducer: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_seq_logic_reducer;

    logic       CLK;
    logic       RST;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] op;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    seq_logic_reducer #(.WIDTH(8), .COUNT(4)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .op(op), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [7:0] d[4];
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // First operand carries op0, the rest carry opr (which must be ignored).
    task automatic feed(input string nm, input logic [1:0] op0,
                        input logic [1:0] opr, input logic [7:0] d0,
                        input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] d3, input logic [7:0] exp);
        logic [7:0] d[4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            op       = (i == 0) ? op0 : opr;
            #1;
            if (i == 0) check({nm, " rdy"}, 32'(in_ready), 32'd1);
            if (i == 3) check({nm, " early"}, 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check({nm, " valid"}, 32'(out_valid), 32'd1);
        check({nm, " data"}, 32'(out_data), 32'(exp));
    endtask

    task automatic handoff(input string nm);
        out_ready = 1'b1;
        tick();
        check({nm, " drain"}, 32'(out_valid), 32'd0);
        check({nm, " idle rdy"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [7:0] model_reduce(input logic [1:0] o,
                                                input logic [7:0] q[$]);
        logic [7:0] r;
        r = (o == 2'b01) ? 8'hFF : 8'h00;
        foreach (q[i]) begin
            case (o)
                2'b01:   r = r & q[i];
                2'b10:   r = r ^ q[i];
                default: r = r | q[i];
            endcase
        end
        return (o == 2'b11) ? ~r : r;
    endfunction

    logic [7:0] mq[$];
    logic [1:0] m_op;
    logic       m_pend;
    logic [7:0] m_res;
    logic       m_acc;

    initial begin
        vecs[0] = '{"or",  2'b00, '{8'h01, 8'h02, 8'h04, 8'h08}, 8'h0F};
        vecs[1] = '{"and", 2'b01, '{8'hFF, 8'hF0, 8'h3C, 8'hFF}, 8'h30};
        vecs[2] = '{"xor", 2'b10, '{8'h55, 8'hAA, 8'h0F, 8'h00}, 8'hF0};
        vecs[3] = '{"nor", 2'b11, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'hFF};

        RST = 1'b1; in_valid = 1'b0; in_data = '0; op = '0;
        flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst data", 32'(out_data), 32'd0);
        check("rst rdy", 32'(in_ready), 32'd1);

        foreach (vecs[k]) begin
            feed(vecs[k].name, vecs[k].op, vecs[k].op, vecs[k].d[0],
                 vecs[k].d[1], vecs[k].d[2], vecs[k].d[3], vecs[k].exp);
            handoff(vecs[k].name);
        end

        // Backpressure holds the result and blocks new operands.
        out_ready = 1'b0;
        feed("bp", 2'b00, 2'b00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp rdy", 32'(in_ready), 32'd0);
            tick();
            check("bp valid", 32'(out_valid), 32'd1);
            check("bp data", 32'(out_data), 32'h0F);
        end
        in_valid = 1'b0;
        handoff("bp");

        // Flush drops the partial reduction and any same-cycle operand.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 8'h80 : 8'h40;
            op       = 2'b00;
            tick();
        end
        flush   = 1'b1;
        in_data = 8'hFF;
        #1;
        check("flush rdy", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        feed("flush", 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h01, 8'h11);
        handoff("flush");

        feed("optog", 2'b00, 2'b01, 8'h0F, 8'h00, 8'h00, 8'hF0, 8'hFF);
        handoff("optog");

        // Reset mid-reduction discards partial state.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC3;
            op       = 2'b00;
            tick();
        end
        in_valid = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mrst valid", 32'(out_valid), 32'd0);
        check("mrst data", 32'(out_data), 32'd0);
        check("mrst rdy", 32'(in_ready), 32'd1);
        feed("mrst", 2'b00, 2'b00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        handoff("mrst");

        // Randomized traffic against the queue model.
        mq.delete();
        m_pend = 1'b0;
        m_op   = 2'b00;
        m_res  = 8'h00;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            op        = 2'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            m_acc     = in_valid && !m_pend && !flush;
            #1;
            check("rnd rdy", 32'(in_ready), 32'(!m_pend && !flush));
            tick();
            if (m_pend) begin
                if (out_ready) m_pend = 1'b0;
            end else if (flush) begin
                mq.delete();
            end else if (m_acc) begin
                if (mq.size() == 0) m_op = op;
                mq.push_back(in_data);
                if (mq.size() == 4) begin
                    m_res  = model_reduce(m_op, mq);
                    m_pend = 1'b1;
                    mq.delete();
                end
            end
            check("rnd valid", 32'(out_valid), 32'(m_pend));
            if (m_pend)
                check("rnd data", 32'(out_data), 32'(m_res));
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
